prio_sel_arb: RTL and testbench
===============================

# prio_sel_arb

Three-channel fixed-priority selector with valid/ready handshakes and a registered output. It sits directly upstream of the priority-if data-select stage: it turns three independent producer channels (a, b, c) into one ordered output stream, so the downstream stage sees at most one qualified source per cycle. It also reports which channel won and counts contended arbitration cycles.

## Interface
- DW, 8 — data width of every channel.
- STARVE_LIM, 4 — consecutive lost arbitrations before a low-priority channel is promoted. Range 1..15. Used only when the starvation guard is compiled in.

Ports:
- clk  in  1  — single clock; all state updates on rising edge.
- rst  in  1  — synchronous, active-high reset.
- a_data / b_data / c_data  in  DW  — channel payloads.
- a_valid / b_valid / c_valid  in  1  — channel holds a valid word.
- a_ready / b_ready / c_ready  out  1  — channel word is accepted this cycle.
- y_data  out  DW  — registered selected payload.
- y_valid  out  1  — y_data holds an unconsumed word.
- y_ready  in  1  — downstream accepts y_data.
- y_src  out  2  — source of y_data: 0 none, 1 a, 2 b, 3 c.
- collide_cnt  out  8  — saturating count of contended arbitrations.

## Operation
- load = !y_valid || y_ready. Arbitration occurs only when load is 1.
- Base priority is a > b > c. The winner is the highest-priority channel with valid=1.
- x_ready is combinational: it is 1 only for the winner, only when load=1 and rst=0. All other readies are 0.
- On load with a winner, the next edge captures:
  - y_data ← winner data
  - y_valid ← 1
  - y_src ← winner code
- On load with no valid input, the next edge captures y_valid ← 0 and y_src ← 0. y_data holds its value.
- When y_valid=1 and y_ready=0 (stall), y_data, y_valid and y_src all hold, and every ready is 0.
- A channel transfer occurs when x_valid && x_ready. Inputs must hold data while valid and not ready; this is not checked.
- Contention: an arbitration with two or more valid inputs increments collide_cnt by 1. collide_cnt saturates at 255 and does not wrap.

## Timing
- Latency is 1 cycle from input transfer to y_valid.
- Throughput is one word per cycle while y_ready=1.
- Simultaneous drain and load are allowed: y_valid stays 1 and the new word replaces the old one in the same cycle.
- Reset values: y_data=0, y_valid=0, y_src=0, collide_cnt=0, starvation counters=0. All readies are 0 while rst=1.
- Reset asserted mid-stall discards the held word. After reset deassertion, the first arbitration happens in that same cycle.

## Configuration
- Macro: PRIO_SEL_ARB_STARVE_GUARD_EN.
- Defined:
  - Channels b and c each have a 4-bit loss counter.
  - A counter increments when load=1, its channel is valid, and it loses.
  - It clears to 0 when the channel is granted or its valid drops.
  - It saturates at STARVE_LIM.
  - A channel whose counter equals STARVE_LIM is promoted above a.
  - If b and c are both promoted, c wins, and b remains promoted.
- Undefined: strict a > b > c priority. The counters and STARVE_LIM logic are absent.

## Test plan
- Reset then single source: rst for 2 cycles, then a_valid=1 with a_data=8'h11 and y_ready=1. Required: a_ready=1 in that cycle; next cycle y_valid=1, y_data=8'h11, y_src=1; all readies 0 during rst.
- Contention: a, b and c all valid with 1/2/3 and y_ready=1. Required: a wins; next cycle y_src=1, y_data=1, collide_cnt=1. Then drop a_valid: b wins and collide_cnt=2.
- Back-pressure: y_valid=1, y_ready=0 for 3 cycles with b_valid=1. Required: y_data/y_src stable and b_ready=0 throughout. Raise y_ready: b_ready=1 in that cycle; next cycle y_data=b_data, y_src=2.
- Idle drain: a single word with y_ready=1 and no further valids. Required: y_valid=1 for exactly one cycle, then y_valid=0 and y_src=0.
- Saturation: hold a and b valid for 300 arbitrations. Required: collide_cnt=255 and stays at 255.
- Starvation (macro defined, STARVE_LIM=4): a and c permanently valid. Required: c wins on the 5th arbitration (y_src=3), then a resumes. With the macro undefined, c never wins.

Source files
------------

// File: rtl/prio_sel_arb.sv
// Three-channel fixed-priority selector (a > b > c) with a registered valid/ready output stage.
// Define PRIO_SEL_ARB_STARVE_GUARD_EN to add loss counters that promote starved b/c channels.
module prio_sel_arb #(
  parameter int unsigned DW         = 8,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] a_data,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [DW-1:0] b_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [DW-1:0] c_data,
  input  logic          c_valid,
  output logic          c_ready,
  output logic [DW-1:0] y_data,
  output logic          y_valid,
  input  logic          y_ready,
  output logic [1:0]    y_src,
  output logic [7:0]    collide_cnt
);

  if (STARVE_LIM < 1 || STARVE_LIM > 15) begin : gen_lim_check
    $error("STARVE_LIM must be in 1..15");
  end

  logic [DW-1:0] y_data_q;
  logic          y_valid_q;
  logic [1:0]    y_src_q;
  logic [7:0]    collide_q;

  logic          load;
  logic [2:0]    grant;  // one-hot {c, b, a}
  logic [1:0]    win_src;
  logic [DW-1:0] win_data;
  logic          contend;

  assign load    = !y_valid_q || y_ready;
  assign contend = (a_valid && b_valid) || (a_valid && c_valid) || (b_valid && c_valid);

`ifdef PRIO_SEL_ARB_STARVE_GUARD_EN
  localparam logic [3:0] Lim = 4'(STARVE_LIM);

  logic [3:0] b_starve_q, b_starve_d;
  logic [3:0] c_starve_q, c_starve_d;
  logic       b_promo, c_promo;

  assign b_promo = b_valid && (b_starve_q == Lim);
  assign c_promo = c_valid && (c_starve_q == Lim);

  // Promoted channels outrank a; c beats b when both are promoted.
  always_comb begin
    grant = 3'b000;
    if (c_promo)      grant = 3'b100;
    else if (b_promo) grant = 3'b010;
    else if (a_valid) grant = 3'b001;
    else if (b_valid) grant = 3'b010;
    else if (c_valid) grant = 3'b100;
  end

  always_comb begin
    b_starve_d = b_starve_q;
    c_starve_d = c_starve_q;
    if (!b_valid) begin
      b_starve_d = 4'd0;
    end else if (load) begin
      if (grant[1])                b_starve_d = 4'd0;
      else if (b_starve_q != Lim)  b_starve_d = b_starve_q + 4'd1;
    end
    if (!c_valid) begin
      c_starve_d = 4'd0;
    end else if (load) begin
      if (grant[2])                c_starve_d = 4'd0;
      else if (c_starve_q != Lim)  c_starve_d = c_starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      b_starve_q <= 4'd0;
      c_starve_q <= 4'd0;
    end else begin
      b_starve_q <= b_starve_d;
      c_starve_q <= c_starve_d;
    end
  end
`else
  always_comb begin
    grant = 3'b000;
    if (a_valid)      grant = 3'b001;
    else if (b_valid) grant = 3'b010;
    else if (c_valid) grant = 3'b100;
  end
`endif

  always_comb begin
    win_src  = 2'd0;
    win_data = y_data_q;
    unique case (grant)
      3'b001: begin win_src = 2'd1; win_data = a_data; end
      3'b010: begin win_src = 2'd2; win_data = b_data; end
      3'b100: begin win_src = 2'd3; win_data = c_data; end
      default: ;
    endcase
  end

  always_comb begin
    a_ready = !rst && load && grant[0];
    b_ready = !rst && load && grant[1];
    c_ready = !rst && load && grant[2];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_data_q  <= '0;
      y_valid_q <= 1'b0;
      y_src_q   <= 2'd0;
      collide_q <= 8'd0;
    end else if (load) begin
      if (grant != 3'b000) begin
        y_data_q  <= win_data;
        y_valid_q <= 1'b1;
        y_src_q   <= win_src;
      end else begin
        y_valid_q <= 1'b0;
        y_src_q   <= 2'd0;
      end
      if (contend && collide_q != 8'hFF) collide_q <= collide_q + 8'd1;
    end
  end

  assign y_data      = y_data_q;
  assign y_valid     = y_valid_q;
  assign y_src       = y_src_q;
  assign collide_cnt = collide_q;

endmodule

// File: tb/tb_prio_sel_arb.sv
// Directed bench for prio_sel_arb: scoreboard of expected output words plus a small
// behavioural model of load, priority, contention count and (optionally) starvation.
module tb_prio_sel_arb;
  localparam int unsigned DW  = 8;
  localparam int unsigned LIM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] a_data, b_data, c_data, y_data;
  logic          a_valid, b_valid, c_valid, y_valid, y_ready;
  logic          a_ready, b_ready, c_ready;
  logic [1:0]    y_src;
  logic [7:0]    collide_cnt;

  prio_sel_arb #(.DW(DW), .STARVE_LIM(LIM)) dut (
    .clk(clk), .rst(rst),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .c_data(c_data), .c_valid(c_valid), .c_ready(c_ready),
    .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready),
    .y_src(y_src), .collide_cnt(collide_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] src;
  } word_t;

  word_t sb[$];
  int errors = 0;
  int checks = 0;

  logic       m_yv;
  logic [7:0] m_ydata;
  logic [1:0] m_ysrc;
  int         m_cnt, m_bc, m_cc;
  logic [1:0] src_log[6];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] pick();
`ifdef PRIO_SEL_ARB_STARVE_GUARD_EN
    if (c_valid && m_cc == LIM) return 2'd3;
    if (b_valid && m_bc == LIM) return 2'd2;
`endif
    if (a_valid) return 2'd1;
    if (b_valid) return 2'd2;
    if (c_valid) return 2'd3;
    return 2'd0;
  endfunction

  // One clock of normal operation: check readies, predict, then check registered outputs.
  task automatic tick(input string tag);
    logic       load;
    logic [1:0] w;
    logic [7:0] wd;
    int         nv;
    word_t      e;
    #1;
    load = !m_yv || y_ready;
    w    = pick();
    wd   = (w == 2'd1) ? a_data : (w == 2'd2) ? b_data : c_data;
    chk({tag, " a_ready"}, a_ready, load && w == 2'd1);
    chk({tag, " b_ready"}, b_ready, load && w == 2'd2);
    chk({tag, " c_ready"}, c_ready, load && w == 2'd3);
    if (load && w != 2'd0) sb.push_back('{data: wd, src: w});
    nv = int'(a_valid) + int'(b_valid) + int'(c_valid);
    if (load && nv >= 2 && m_cnt != 255) m_cnt++;
`ifdef PRIO_SEL_ARB_STARVE_GUARD_EN
    if (!b_valid) m_bc = 0;
    else if (load) m_bc = (w == 2'd2) ? 0 : (m_bc < LIM ? m_bc + 1 : m_bc);
    if (!c_valid) m_cc = 0;
    else if (load) m_cc = (w == 2'd3) ? 0 : (m_cc < LIM ? m_cc + 1 : m_cc);
`endif
    @(posedge clk);
    #1;
    if (load && w != 2'd0) begin
      e       = sb.pop_front();
      m_yv    = 1'b1;
      m_ydata = e.data;
      m_ysrc  = e.src;
    end else if (load) begin
      m_yv   = 1'b0;
      m_ysrc = 2'd0;
    end
    chk({tag, " y_valid"}, y_valid, m_yv);
    chk({tag, " y_data"}, y_data, m_ydata);
    chk({tag, " y_src"}, y_src, m_ysrc);
    chk({tag, " collide_cnt"}, collide_cnt, m_cnt);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      #1;
      chk("rst a_ready", a_ready, 1'b0);
      chk("rst b_ready", b_ready, 1'b0);
      chk("rst c_ready", c_ready, 1'b0);
      @(posedge clk);
      #1;
      chk("rst y_valid", y_valid, 1'b0);
      chk("rst y_data", y_data, 8'h00);
      chk("rst y_src", y_src, 2'd0);
      chk("rst collide_cnt", collide_cnt, 8'd0);
    end
    rst     = 1'b0;
    m_yv    = 1'b0;
    m_ydata = 8'h00;
    m_ysrc  = 2'd0;
    m_cnt   = 0;
    m_bc    = 0;
    m_cc    = 0;
    sb.delete();
  endtask

  initial begin
    rst = 1'b1;
    a_data = 8'h11; b_data = 8'h00; c_data = 8'h00;
    a_valid = 1'b1; b_valid = 1'b0; c_valid = 1'b0;
    y_ready = 1'b1;
    do_reset(2);

    // Single source straight out of reset
    tick("single");
    chk("single y_data direct", y_data, 8'h11);
    chk("single y_src direct", y_src, 2'd1);

    // Three-way contention, then b after a drops
    a_data = 8'h01; b_data = 8'h02; c_data = 8'h03;
    a_valid = 1'b1; b_valid = 1'b1; c_valid = 1'b1;
    tick("contend3");
    chk("contend3 src direct", y_src, 2'd1);
    chk("contend3 cnt direct", collide_cnt, 8'd1);
    a_valid = 1'b0;
    tick("contend2");
    chk("contend2 src direct", y_src, 2'd2);
    chk("contend2 cnt direct", collide_cnt, 8'd2);

    // Back-pressure: three stalled cycles, then release
    c_valid = 1'b0;
    b_data  = 8'h22;
    y_ready = 1'b0;
    repeat (3) tick("stall");
    chk("stall data held", y_data, 8'h02);
    y_ready = 1'b1;
    tick("release");
    chk("release data direct", y_data, 8'h22);
    chk("release src direct", y_src, 2'd2);

    // Idle drain
    b_valid = 1'b0;
    a_valid = 1'b1; a_data = 8'h44;
    tick("drain word");
    a_valid = 1'b0;
    tick("drain empty");
    chk("drain y_valid direct", y_valid, 1'b0);
    chk("drain y_src direct", y_src, 2'd0);
    tick("drain idle");

    // Reset in the middle of a stall discards the held word
    a_valid = 1'b1; a_data = 8'h55;
    tick("pre-stall");
    y_ready = 1'b0;
    tick("mid-stall");
    do_reset(1);
    y_ready = 1'b1;
    a_valid = 1'b0;
    tick("post-reset idle");

    // Saturation of the contention counter
    a_valid = 1'b1; b_valid = 1'b1; a_data = 8'h66; b_data = 8'h77;
    repeat (300) tick("sat");
    chk("sat cnt direct", collide_cnt, 8'hFF);
    repeat (2) tick("sat hold");
    chk("sat hold direct", collide_cnt, 8'hFF);

    // Starvation of c behind a
    a_valid = 1'b0; b_valid = 1'b0;
    do_reset(1);
    a_valid = 1'b1; c_valid = 1'b1; a_data = 8'hAA; c_data = 8'hCC;
    for (int i = 0; i < 6; i++) begin
      tick("starve");
      src_log[i] = y_src;
    end
`ifdef PRIO_SEL_ARB_STARVE_GUARD_EN
    chk("starve arb4 src", src_log[3], 2'd1);
    chk("starve arb5 src", src_log[4], 2'd3);
    chk("starve arb6 src", src_log[5], 2'd1);
`else
    for (int i = 0; i < 6; i++) chk("starve c never wins", src_log[i] == 2'd3, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
